vme_bus_arbiter: RTL and testbench

//  Two-master arbiter sharing one VME-style register-bank slave port (RdMem/WrMem strobe, RdDone/WrDone ack).

---
 rtl/vme_bus_arbiter_if.sv | 66 ++++++
 rtl/vme_bus_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_vme_bus_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/vme_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// vme_bus_arbiter_if
// Purpose : bundles the two master request ports and the single register-bank
//           slave port of vme_bus_arbiter into one interface.
// Modports:
//   slave  - view taken by the arbiter: it receives master requests and slave
//            acks, and drives master responses and slave strobes.
//   master - view taken by the environment (bus decoders and register bank):
//            drives requests and acks, observes responses and strobes.
// Signals :
//   mX_rd_i / mX_wr_i   level requests, held until mX_done_o
//   mX_adr_i / mX_dat_i request address / write data
//   mX_dat_o            read data, valid with mX_done_o, held until next read
//   mX_done_o           one-cycle completion pulse
//   mX_err_o            timeout flag, coincident with mX_done_o
//   s_adr_o / s_wr_dat_o slave address / write data
//   s_rd_mem_o / s_wr_mem_o one-cycle slave strobes
//   s_rd_dat_i          slave read data, valid with s_rd_done_i
//   s_rd_done_i / s_wr_done_i slave acks
// ---------------------------------------------------------------------------
interface vme_bus_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  logic          m0_rd_i;
  logic          m0_wr_i;
  logic [AW-1:0] m0_adr_i;
  logic [DW-1:0] m0_dat_i;
  logic [DW-1:0] m0_dat_o;
  logic          m0_done_o;
  logic          m0_err_o;

  logic          m1_rd_i;
  logic          m1_wr_i;
  logic [AW-1:0] m1_adr_i;
  logic [DW-1:0] m1_dat_i;
  logic [DW-1:0] m1_dat_o;
  logic          m1_done_o;
  logic          m1_err_o;

  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_wr_dat_o;
  logic          s_rd_mem_o;
  logic          s_wr_mem_o;
  logic [DW-1:0] s_rd_dat_i;
  logic          s_rd_done_i;
  logic          s_wr_done_i;

  modport slave (
    input  m0_rd_i, m0_wr_i, m0_adr_i, m0_dat_i,
    output m0_dat_o, m0_done_o, m0_err_o,
    input  m1_rd_i, m1_wr_i, m1_adr_i, m1_dat_i,
    output m1_dat_o, m1_done_o, m1_err_o,
    output s_adr_o, s_wr_dat_o, s_rd_mem_o, s_wr_mem_o,
    input  s_rd_dat_i, s_rd_done_i, s_wr_done_i
  );

  modport master (
    output m0_rd_i, m0_wr_i, m0_adr_i, m0_dat_i,
    input  m0_dat_o, m0_done_o, m0_err_o,
    output m1_rd_i, m1_wr_i, m1_adr_i, m1_dat_i,
    input  m1_dat_o, m1_done_o, m1_err_o,
    input  s_adr_o, s_wr_dat_o, s_rd_mem_o, s_wr_mem_o,
    output s_rd_dat_i, s_rd_done_i, s_wr_done_i
  );
endinterface

// File: rtl/vme_bus_arbiter.sv
// ---------------------------------------------------------------------------
// vme_bus_arbiter
// Purpose : shares one VME-style register-bank port between two masters.
//           Latches one request, issues a single-cycle strobe, waits for the
//           matching done, returns data plus a done pulse to the requester.
//           Contention is resolved by strict alternation (master 0 first).
// Ports   :
//   clk    clock
//   rst_n  synchronous active-low reset (aborts any transaction silently)
//   bus    vme_bus_arbiter_if.slave - master request/response ports and the
//          register-bank strobe/ack port
// Params  : DW data width, AW address width, TMO_CYC WAIT timeout in cycles
// Config  : VME_ARB_TIMEOUT_EN - when defined, WAIT gives up after TMO_CYC
//           cycles without a matching done and reports mX_err_o with the
//           done pulse. Undefined: WAIT is unbounded, err outputs tied 0.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction; sample requests, latch grant/op/adr/data
// ISSUE | one-cycle read or write strobe to the register bank
// WAIT  | wait for the done matching the latched op
// RESP  | one-cycle done (and err) pulse to the granted master
// ---------------------------------------------------------------------------
module vme_bus_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 8,
  parameter int TMO_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vme_bus_arbiter_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  if (TMO_CYC < 1) begin : g_tmo_chk
    $error("vme_bus_arbiter: TMO_CYC must be at least 1");
  end

  state_t        state_q;
  state_t        state_d;

  logic          last_grant_q;
  logic          grant_q;
  logic          op_wr_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wr_dat_q;
  logic [DW-1:0] m0_dat_q;
  logic [DW-1:0] m1_dat_q;

  logic          req0;
  logic          req1;
  logic          any_req;
  logic          grant_nxt;
  logic          wr_nxt;
  logic [AW-1:0] adr_nxt;
  logic [DW-1:0] dat_nxt;
  logic          done_match;
  logic          tmo_hit;

  logic          s_rd_mem;
  logic          s_wr_mem;
  logic          m0_done;
  logic          m1_done;

  assign req0    = bus.m0_rd_i | bus.m0_wr_i;
  assign req1    = bus.m1_rd_i | bus.m1_wr_i;
  assign any_req = req0 | req1;

  // Under contention the master that did not win last time gets the bus.
  always_comb begin
    grant_nxt = req1;
    if (req0 && req1) begin
      grant_nxt = ~last_grant_q;
    end
  end

  // A master raising rd and wr together is treated as a write.
  assign wr_nxt  = grant_nxt ? bus.m1_wr_i  : bus.m0_wr_i;
  assign adr_nxt = grant_nxt ? bus.m1_adr_i : bus.m0_adr_i;
  assign dat_nxt = grant_nxt ? bus.m1_dat_i : bus.m0_dat_i;

  // Only the ack for the latched op counts; the other one is ignored.
  assign done_match = op_wr_q ? bus.s_wr_done_i : bus.s_rd_done_i;

`ifdef VME_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TMO_CYC) > 8) ? $clog2(TMO_CYC) : 8;

  logic [CW-1:0] tmo_cnt_q;
  logic          err_q;

  // Counter holds the number of completed WAIT cycles, so the last allowed
  // WAIT cycle is the one where it reads TMO_CYC-1.
  assign tmo_hit = (tmo_cnt_q == CW'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tmo_cnt_q <= '0;
          err_q     <= 1'b0;
        end
        ISSUE: tmo_cnt_q <= '0;
        WAIT: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          if (!done_match && tmo_hit) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m0_err_o = m0_done & err_q;
  assign bus.m1_err_o = m1_done & err_q;
`else
  assign tmo_hit      = 1'b0;
  assign bus.m0_err_o = 1'b0;
  assign bus.m1_err_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done_match || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    s_rd_mem = 1'b0;
    s_wr_mem = 1'b0;
    m0_done  = 1'b0;
    m1_done  = 1'b0;
    case (state_q)
      ISSUE: begin
        s_rd_mem = ~op_wr_q;
        s_wr_mem = op_wr_q;
      end
      RESP: begin
        m0_done = ~grant_q;
        m1_done = grant_q;
      end
      default: ;
    endcase
  end

  // Request latch, read-data capture and fairness bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      op_wr_q      <= 1'b0;
      adr_q        <= '0;
      wr_dat_q     <= '0;
      m0_dat_q     <= '0;
      m1_dat_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q  <= grant_nxt;
            op_wr_q  <= wr_nxt;
            adr_q    <= adr_nxt;
            wr_dat_q <= dat_nxt;
          end
        end
        WAIT: begin
          if (done_match) begin
            if (!op_wr_q) begin
              if (grant_q) m1_dat_q <= bus.s_rd_dat_i;
              else         m0_dat_q <= bus.s_rd_dat_i;
            end
          end else if (tmo_hit && !op_wr_q) begin
            // Timed-out reads return zero rather than stale data.
            if (grant_q) m1_dat_q <= '0;
            else         m0_dat_q <= '0;
          end
        end
        RESP: last_grant_q <= grant_q;
        default: ;
      endcase
    end
  end

  assign bus.s_adr_o    = adr_q;
  assign bus.s_wr_dat_o = wr_dat_q;
  assign bus.s_rd_mem_o = s_rd_mem;
  assign bus.s_wr_mem_o = s_wr_mem;
  assign bus.m0_dat_o   = m0_dat_q;
  assign bus.m1_dat_o   = m1_dat_q;
  assign bus.m0_done_o  = m0_done;
  assign bus.m1_done_o  = m1_done;

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vme_bus_arbiter
// Directed bench for vme_bus_arbiter. Inputs change and outputs are observed
// on the falling clock edge, so each step sees the state entered at the
// preceding rising edge.
// ---------------------------------------------------------------------------
module tb_vme_bus_arbiter;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  vme_bus_arbiter_if #(.DW(32), .AW(8)) bus ();

  vme_bus_arbiter #(.DW(32), .AW(8), .TMO_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction with a zero-wait slave. Starts and ends on an IDLE
  // cycle with the request(s) already presented.
  task automatic serve(input bit m, input bit wr, input logic [7:0] adr,
                       input logic [31:0] rdat, input logic [31:0] wdat);
    tick;
    chk("srv_rd_mem", {31'b0, bus.s_rd_mem_o}, {31'b0, ~wr});
    chk("srv_wr_mem", {31'b0, bus.s_wr_mem_o}, {31'b0, wr});
    chk("srv_adr", {24'b0, bus.s_adr_o}, {24'b0, adr});
    if (wr) chk("srv_wdat", bus.s_wr_dat_o, wdat);
    tick;
    chk("srv_strobe_1cyc", {30'b0, bus.s_rd_mem_o, bus.s_wr_mem_o}, 32'd0);
    if (wr) begin
      bus.s_wr_done_i = 1'b1;
    end else begin
      bus.s_rd_done_i = 1'b1;
      bus.s_rd_dat_i  = rdat;
    end
    tick;
    bus.s_wr_done_i = 1'b0;
    bus.s_rd_done_i = 1'b0;
    bus.s_rd_dat_i  = 32'h0;
    chk("srv_done0", {31'b0, bus.m0_done_o}, {31'b0, ~m});
    chk("srv_done1", {31'b0, bus.m1_done_o}, {31'b0, m});
    chk("srv_err", {30'b0, bus.m0_err_o, bus.m1_err_o}, 32'd0);
    if (!wr) chk("srv_rdat", m ? bus.m1_dat_o : bus.m0_dat_o, rdat);
    tick;
    chk("srv_done_pulse", {30'b0, bus.m0_done_o, bus.m1_done_o}, 32'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.m0_rd_i = 1'b0; bus.m0_wr_i = 1'b0; bus.m0_adr_i = 8'h0; bus.m0_dat_i = 32'h0;
    bus.m1_rd_i = 1'b0; bus.m1_wr_i = 1'b0; bus.m1_adr_i = 8'h0; bus.m1_dat_i = 32'h0;
    bus.s_rd_dat_i = 32'h0; bus.s_rd_done_i = 1'b0; bus.s_wr_done_i = 1'b0;

    // Reset state
    tick; tick;
    chk("rst_strobes", {30'b0, bus.s_rd_mem_o, bus.s_wr_mem_o}, 32'd0);
    chk("rst_done", {30'b0, bus.m0_done_o, bus.m1_done_o}, 32'd0);
    chk("rst_err", {30'b0, bus.m0_err_o, bus.m1_err_o}, 32'd0);
    chk("rst_adr", {24'b0, bus.s_adr_o}, 32'd0);
    chk("rst_wdat", bus.s_wr_dat_o, 32'd0);
    chk("rst_m0_dat", bus.m0_dat_o, 32'd0);
    chk("rst_m1_dat", bus.m1_dat_o, 32'd0);
    rst_n = 1'b1;
    tick;

    // 1: m0 write, slave acks two cycles after the strobe
    bus.m0_wr_i = 1'b1; bus.m0_adr_i = 8'h04; bus.m0_dat_i = 32'h0000ABCD;
    tick;
    chk("t1_wr_mem", {31'b0, bus.s_wr_mem_o}, 32'd1);
    chk("t1_rd_mem", {31'b0, bus.s_rd_mem_o}, 32'd0);
    chk("t1_adr", {24'b0, bus.s_adr_o}, 32'h04);
    chk("t1_wdat", bus.s_wr_dat_o, 32'h0000ABCD);
    tick;
    chk("t1_wr_mem_1cyc", {31'b0, bus.s_wr_mem_o}, 32'd0);
    chk("t1_no_early_done", {31'b0, bus.m0_done_o}, 32'd0);
    tick;
    bus.s_wr_done_i = 1'b1;
    chk("t1_still_waiting", {31'b0, bus.m0_done_o}, 32'd0);
    tick;
    bus.s_wr_done_i = 1'b0;
    bus.m0_wr_i = 1'b0;
    chk("t1_m0_done", {31'b0, bus.m0_done_o}, 32'd1);
    chk("t1_m1_done", {31'b0, bus.m1_done_o}, 32'd0);
    chk("t1_adr_stable", {24'b0, bus.s_adr_o}, 32'h04);
    tick;
    chk("t1_done_pulse", {31'b0, bus.m0_done_o}, 32'd0);
    chk("t1_m1_dat", bus.m1_dat_o, 32'd0);

    // 2: m1 read, slave acks one cycle after the strobe
    bus.m1_rd_i = 1'b1; bus.m1_adr_i = 8'h00;
    tick;
    chk("t2_rd_mem", {31'b0, bus.s_rd_mem_o}, 32'd1);
    chk("t2_adr", {24'b0, bus.s_adr_o}, 32'h00);
    chk("t2_no_done_c2", {31'b0, bus.m1_done_o}, 32'd0);
    tick;
    bus.s_rd_done_i = 1'b1; bus.s_rd_dat_i = 32'h00001234;
    chk("t2_no_done_c3", {31'b0, bus.m1_done_o}, 32'd0);
    tick;
    bus.s_rd_done_i = 1'b0; bus.s_rd_dat_i = 32'h0;
    bus.m1_rd_i = 1'b0;
    chk("t2_m1_done_c4", {31'b0, bus.m1_done_o}, 32'd1);
    chk("t2_m1_dat", bus.m1_dat_o, 32'h00001234);
    chk("t2_m0_dat", bus.m0_dat_o, 32'd0);
    tick;
    chk("t2_done_pulse", {31'b0, bus.m1_done_o}, 32'd0);
    chk("t2_dat_hold", bus.m1_dat_o, 32'h00001234);

    // 3: both masters request from reset and hold -> m0, m1, m0, m1
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    bus.m0_rd_i = 1'b1; bus.m0_adr_i = 8'h10;
    bus.m1_wr_i = 1'b1; bus.m1_adr_i = 8'h20; bus.m1_dat_i = 32'h000055AA;
    serve(1'b0, 1'b0, 8'h10, 32'h11110000, 32'h0);
    serve(1'b1, 1'b1, 8'h20, 32'h0, 32'h000055AA);
    serve(1'b0, 1'b0, 8'h10, 32'h22220000, 32'h0);
    serve(1'b1, 1'b1, 8'h20, 32'h0, 32'h000055AA);
    bus.m0_rd_i = 1'b0; bus.m1_wr_i = 1'b0;
    chk("t3_m1_dat_untouched", bus.m1_dat_o, 32'd0);

    // 4: rd+wr together -> write; stray read done ignored
    bus.m0_rd_i = 1'b1; bus.m0_wr_i = 1'b1; bus.m0_adr_i = 8'h30; bus.m0_dat_i = 32'h00000077;
    tick;
    chk("t4_wr_mem", {31'b0, bus.s_wr_mem_o}, 32'd1);
    chk("t4_rd_mem", {31'b0, bus.s_rd_mem_o}, 32'd0);
    tick;
    bus.s_rd_done_i = 1'b1; bus.s_rd_dat_i = 32'hDEADBEEF;
    tick;
    bus.s_rd_done_i = 1'b0; bus.s_rd_dat_i = 32'h0;
    chk("t4_stray_ignored", {31'b0, bus.m0_done_o}, 32'd0);
    bus.s_wr_done_i = 1'b1;
    tick;
    bus.s_wr_done_i = 1'b0;
    bus.m0_rd_i = 1'b0; bus.m0_wr_i = 1'b0;
    chk("t4_done", {31'b0, bus.m0_done_o}, 32'd1);
    chk("t4_dat_unchanged", bus.m0_dat_o, 32'h22220000);
    tick;

    // 5: reset in WAIT aborts silently; next request completes
    bus.m1_rd_i = 1'b1; bus.m1_adr_i = 8'h40;
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    chk("t5_done", {30'b0, bus.m0_done_o, bus.m1_done_o}, 32'd0);
    chk("t5_strobes", {30'b0, bus.s_rd_mem_o, bus.s_wr_mem_o}, 32'd0);
    chk("t5_adr", {24'b0, bus.s_adr_o}, 32'd0);
    chk("t5_m0_dat", bus.m0_dat_o, 32'd0);
    rst_n = 1'b1;
    bus.m1_rd_i = 1'b0;
    tick;
    chk("t5_idle_no_done", {30'b0, bus.m0_done_o, bus.m1_done_o}, 32'd0);
    bus.m1_rd_i = 1'b1; bus.m1_adr_i = 8'h44;
    serve(1'b1, 1'b0, 8'h44, 32'h0000BEEF, 32'h0);
    bus.m1_rd_i = 1'b0;

`ifdef VME_ARB_TIMEOUT_EN
    // 6: slave never acks -> done+err 17 cycles after the strobe, data zeroed
    bus.m0_rd_i = 1'b1; bus.m0_adr_i = 8'h60;
    serve(1'b0, 1'b0, 8'h60, 32'h5A5A5A5A, 32'h0);
    tick;
    chk("t6_rd_mem", {31'b0, bus.s_rd_mem_o}, 32'd1);
    for (int k = 1; k <= 16; k++) begin
      tick;
      chk("t6_no_done", {31'b0, bus.m0_done_o}, 32'd0);
    end
    tick;
    bus.m0_rd_i = 1'b0;
    chk("t6_done", {31'b0, bus.m0_done_o}, 32'd1);
    chk("t6_err", {31'b0, bus.m0_err_o}, 32'd1);
    chk("t6_dat_zero", bus.m0_dat_o, 32'd0);
    tick;
    bus.s_rd_done_i = 1'b1;
    tick;
    bus.s_rd_done_i = 1'b0;
    chk("t6_late_done", {30'b0, bus.m0_done_o, bus.m0_err_o}, 32'd0);
`else
    // 6: without the timeout WAIT is unbounded and err stays low
    bus.m0_wr_i = 1'b1; bus.m0_adr_i = 8'h50; bus.m0_dat_i = 32'h00000001;
    tick;
    chk("t6_wr_mem", {31'b0, bus.s_wr_mem_o}, 32'd1);
    for (int k = 1; k <= 30; k++) begin
      tick;
      chk("t6_unbounded", {31'b0, bus.m0_done_o}, 32'd0);
    end
    bus.s_wr_done_i = 1'b1;
    tick;
    bus.s_wr_done_i = 1'b0;
    bus.m0_wr_i = 1'b0;
    chk("t6_done", {31'b0, bus.m0_done_o}, 32'd1);
    chk("t6_err_tied", {30'b0, bus.m0_err_o, bus.m1_err_o}, 32'd0);
    tick;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
